muldiv_unit: RTL and testbench

MULDIV_UNIT -- requirements
Module: muldiv_unit

---
 rtl/lc3b_types.sv | 26 ++
 rtl/muldiv_unit.sv | 127 ++++++++++++
 tb/tb_muldiv_unit.sv | 205 ++++++++++++++++++++
 3 files changed

// File: rtl/lc3b_types.sv
// Shared LC-3b types: ALU operation codes and the multiply/divide sequencer states.
// Also holds the default iteration count of the iterative multiply/divide unit.
package lc3b_types;

   localparam int MULDIV_ITERS = 16;

   typedef enum logic [3:0] {
      alu_add,
      alu_and,
      alu_not,
      alu_pass,
      alu_sll,
      alu_srl,
      alu_sra,
      alu_mult,
      alu_div
   } lc3b_aluop;

   typedef enum logic [1:0] {
      IDLE,
      MUL,
      DIV,
      DONE
   } muldiv_state;

endpackage

// File: rtl/muldiv_unit.sv
// Iterative unsigned multiply / restoring divide; done ITERS+1 edges after accept (1 for divide-by-zero).
// No backpressure: start is accepted only from IDLE/DONE and ignored while busy; flush aborts silently.
module muldiv_unit
   import lc3b_types::*;
#(
   parameter int WIDTH = 16,
   parameter int ITERS = WIDTH
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  lc3b_aluop        aluop,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             flush,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] result,
   output logic [WIDTH-1:0] remainder,
   output logic             div_by_zero
);

   localparam int CW = (ITERS > 1) ? $clog2(ITERS) : 1;

   muldiv_state        state, next_state;
   logic [CW-1:0]      cnt;
   logic [WIDTH-1:0]   a_q, b_q;
   lc3b_aluop          op_q;
   logic [2*WIDTH-1:0] acc;
   logic               accept, last_iter;
   logic [WIDTH:0]     mul_sum, rem_sh, rem_diff;
   logic [2*WIDTH-1:0] acc_mul, acc_div;

   assign accept    = (state == IDLE || state == DONE) && start && !flush &&
                      (aluop == alu_mult || aluop == alu_div);
   assign last_iter = (cnt == CW'(ITERS - 1));

   // Multiply keeps the multiplier in the low half and shifts the product in from the top;
   // divide shifts the dividend out of the low half while quotient bits fill in behind it.
   always_comb begin
      mul_sum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, a_q} : {(WIDTH+1){1'b0}});
      acc_mul  = {mul_sum, acc[WIDTH-1:1]};
      rem_sh   = acc[2*WIDTH-1:WIDTH-1];
      rem_diff = rem_sh - {1'b0, b_q};
      if (rem_diff[WIDTH])
         acc_div = {rem_sh[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
      else
         acc_div = {rem_diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         state <= IDLE;
      else
         state <= next_state;
   end

   always_comb begin
      next_state = state;
      if (flush) begin
         next_state = IDLE;
      end else begin
         case (state)
            IDLE, DONE: begin
               next_state = IDLE;
               if (accept) begin
                  if (aluop == alu_mult)
                     next_state = MUL;
                  else if (b == '0)
                     next_state = DONE;
                  else
                     next_state = DIV;
               end
            end
            MUL, DIV: if (last_iter) next_state = DONE;
            default:  next_state = IDLE;
         endcase
      end
   end

   always_comb begin
      busy = (state == MUL) || (state == DIV);
      done = (state == DONE);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt         <= '0;
         a_q         <= '0;
         b_q         <= '0;
         op_q        <= alu_add;
         acc         <= '0;
         result      <= '0;
         remainder   <= '0;
         div_by_zero <= 1'b0;
      end else if (accept) begin
         a_q  <= a;
         b_q  <= b;
         op_q <= aluop;
         cnt  <= '0;
         acc  <= (aluop == alu_mult) ? {{WIDTH{1'b0}}, b} : {{WIDTH{1'b0}}, a};
         if (aluop == alu_div && b == '0) begin
            result      <= '1;
            remainder   <= a;
            div_by_zero <= 1'b1;
         end
      end else if (busy && !flush) begin
         cnt <= cnt + 1'b1;
         if (op_q == alu_mult) begin
            acc <= acc_mul;
            if (last_iter) begin
               result      <= acc_mul[WIDTH-1:0];
               remainder   <= '0;
               div_by_zero <= 1'b0;
            end
         end else begin
            acc <= acc_div;
            if (last_iter) begin
               result      <= acc_div[WIDTH-1:0];
               remainder   <= acc_div[2*WIDTH-1:WIDTH];
               div_by_zero <= 1'b0;
            end
         end
      end
   end

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed bench for muldiv_unit: latency, arithmetic, back-to-back, ignore-while-busy, flush and reset.
module tb_muldiv_unit;
   import lc3b_types::*;

   logic        clk, rst_n, start, flush;
   lc3b_aluop   aluop;
   logic [15:0] a, b;
   logic        busy, done, div_by_zero;
   logic [15:0] result, remainder;

   int vectors     = 0;
   int miscompares = 0;
   int edges;
   int ndone;

   muldiv_unit #(.WIDTH(16), .ITERS(MULDIV_ITERS)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .start       (start),
      .aluop       (aluop),
      .a           (a),
      .b           (b),
      .flush       (flush),
      .busy        (busy),
      .done        (done),
      .result      (result),
      .remainder   (remainder),
      .div_by_zero (div_by_zero)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Drive a request and let exactly one rising edge sample it.
   task automatic issue(input lc3b_aluop op, input logic [15:0] av, input logic [15:0] bv);
      start = 1'b1;
      aluop = op;
      a     = av;
      b     = bv;
      @(posedge clk);
      #1;
      start = 1'b0;
   endtask

   // Edge count includes the accepting edge; bounded so a missing done cannot hang the run.
   task automatic wait_done(input int from, output int n);
      n = from;
      while (!done && n < 40) begin
         @(posedge clk);
         #1;
         n++;
      end
   endtask

   task automatic count_done(input int cycles, output int n);
      n = 0;
      repeat (cycles) begin
         @(posedge clk);
         #1;
         if (done) n++;
      end
   endtask

   initial begin
      rst_n = 1'b0;
      start = 1'b0;
      flush = 1'b0;
      aluop = alu_add;
      a     = '0;
      b     = '0;
      #12;
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_result", result, 0);
      check("rst_remainder", remainder, 0);
      check("rst_dbz", div_by_zero, 0);

      // First edge after release must accept.
      @(negedge clk);
      rst_n = 1'b1;
      issue(alu_mult, 16'd7, 16'd6);
      check("mul1_busy", busy, 1);
      wait_done(1, edges);
      check("mul1_latency", edges, 17);
      check("mul1_result", result, 16'h002A);
      check("mul1_remainder", remainder, 0);
      check("mul1_busy_at_done", busy, 0);
      @(posedge clk);
      #1;
      check("mul1_done_pulse", done, 0);
      check("mul1_result_hold", result, 16'h002A);

      issue(alu_mult, 16'hFFFF, 16'hFFFF);
      wait_done(1, edges);
      check("mul2_latency", edges, 17);
      check("mul2_result", result, 16'h0001);
      check("mul2_remainder", remainder, 0);

      @(posedge clk);
      #1;
      issue(alu_div, 16'd100, 16'd7);
      wait_done(1, edges);
      check("div1_latency", edges, 17);
      check("div1_result", result, 16'd14);
      check("div1_remainder", remainder, 16'd2);
      check("div1_dbz", div_by_zero, 0);
      // Back-to-back start during the DONE cycle.
      issue(alu_div, 16'd9, 16'd3);
      check("div2_busy", busy, 1);
      check("div2_done", done, 0);
      wait_done(1, edges);
      check("div2_latency", edges, 17);
      check("div2_result", result, 16'd3);
      check("div2_remainder", remainder, 16'd0);

      @(posedge clk);
      #1;
      issue(alu_mult, 16'd3, 16'd5);
      repeat (4) begin
         @(posedge clk);
         #1;
      end
      start = 1'b1;
      aluop = alu_div;
      a     = 16'd100;
      b     = 16'd0;
      @(posedge clk);
      #1;
      start = 1'b0;
      check("ign_busy", busy, 1);
      wait_done(6, edges);
      check("ign_latency", edges, 17);
      check("ign_result", result, 16'h000F);
      check("ign_remainder", remainder, 0);
      check("ign_dbz", div_by_zero, 0);

      @(posedge clk);
      #1;
      issue(alu_mult, 16'd7, 16'd6);
      repeat (7) begin
         @(posedge clk);
         #1;
      end
      flush = 1'b1;
      start = 1'b1;
      aluop = alu_mult;
      a     = 16'd2;
      b     = 16'd2;
      @(posedge clk);
      #1;
      flush = 1'b0;
      start = 1'b0;
      check("flush_busy", busy, 0);
      check("flush_done", done, 0);
      check("flush_result_hold", result, 16'h000F);
      count_done(30, ndone);
      check("flush_no_done", ndone, 0);

      issue(alu_div, 16'h1234, 16'h0000);
      check("dbz_done_1edge", done, 1);
      check("dbz_busy", busy, 0);
      check("dbz_result", result, 16'hFFFF);
      check("dbz_remainder", remainder, 16'h1234);
      check("dbz_flag", div_by_zero, 1);
      @(posedge clk);
      #1;
      check("dbz_done_pulse", done, 0);
      check("dbz_flag_hold", div_by_zero, 1);

      issue(alu_add, 16'd1, 16'd1);
      check("badop_busy", busy, 0);
      check("badop_done", done, 0);
      check("badop_result_hold", result, 16'hFFFF);

      issue(alu_div, 16'd100, 16'd7);
      repeat (9) begin
         @(posedge clk);
         #1;
      end
      rst_n = 1'b0;
      #1;
      check("midrst_busy", busy, 0);
      check("midrst_done", done, 0);
      check("midrst_result", result, 0);
      check("midrst_remainder", remainder, 0);
      check("midrst_dbz", div_by_zero, 0);
      @(negedge clk);
      rst_n = 1'b1;
      count_done(30, ndone);
      check("midrst_no_done", ndone, 0);
      check("midrst_idle", busy, 0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
